// File: rtl/molecule_cross_counter_if.sv
// molecule_cross_counter_if: frame control, molecule positions and crossing statistics bundle.
interface molecule_cross_counter_if;
    logic       frame;
    logic       freeze;
    logic       clear;
    logic [9:0] membrane_x;
    logic [9:0] pos_x_0;
    logic [9:0] pos_x_1;
    logic [9:0] pos_x_2;
    logic [9:0] pos_x_3;
    logic [2:0] count_left;
    logic [2:0] count_right;
    logic [7:0] total_lr;
    logic [7:0] total_rl;
    logic       scan_done;
    modport master (
        output frame, freeze, clear, membrane_x, pos_x_0, pos_x_1, pos_x_2, pos_x_3,
        input  count_left, count_right, total_lr, total_rl, scan_done
    );
    modport slave (
        input  frame, freeze, clear, membrane_x, pos_x_0, pos_x_1, pos_x_2, pos_x_3,
        output count_left, count_right, total_lr, total_rl, scan_done
    );
endinterface

// File: rtl/molecule_cross_counter.sv
// molecule_cross_counter: per-frame scan of molecule sides relative to a membrane, counting crossings.
module molecule_cross_counter #(
    parameter int MOL_SIZE = 16,
    parameter int N_MOL    = 4
) (
    input logic                      clk,
    input logic                      reset,
    molecule_cross_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t                  state_q;
    logic [1:0]              idx_q;
    logic [N_MOL-1:0][9:0]   snap_q;
    logic [2:0]              left_tmp_q;
    logic [N_MOL-1:0]        known_q;
    logic [N_MOL-1:0]        side_q;
    logic [2:0]              count_left_q;
    logic [2:0]              count_right_q;
    logic [7:0]              total_lr_q;
    logic [7:0]              total_rl_q;
    logic                    scan_done_q;
    logic [10:0]             center_d;
    logic                    side_d;
    logic                    cross_lr;
    logic                    cross_rl;
    // Centre is widened to 11 bits so sprites near the right edge never wrap to the left side.
    always_comb begin
        center_d = {1'b0, snap_q[idx_q]} + 11'(MOL_SIZE / 2);
        side_d   = center_d >= {1'b0, bus.membrane_x};
        cross_lr = state_q == SCAN && known_q[idx_q] && !side_q[idx_q] && side_d;
        cross_rl = state_q == SCAN && known_q[idx_q] && side_q[idx_q] && !side_d;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            snap_q        <= '0;
            left_tmp_q    <= '0;
            known_q       <= '0;
            side_q        <= '0;
            count_left_q  <= '0;
            count_right_q <= '0;
            total_lr_q    <= '0;
            total_rl_q    <= '0;
            scan_done_q   <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.frame && !bus.freeze) begin
                    snap_q     <= {bus.pos_x_3, bus.pos_x_2, bus.pos_x_1, bus.pos_x_0};
                    idx_q      <= '0;
                    left_tmp_q <= '0;
                    state_q    <= SCAN;
                end
                SCAN: begin
                    side_q[idx_q]  <= side_d;
                    known_q[idx_q] <= 1'b1;
                    left_tmp_q     <= left_tmp_q + {2'b0, ~side_d};
                    idx_q          <= idx_q + 2'd1;
                    if (idx_q == 2'd3) state_q <= DONE;
                end
                DONE: begin
                    count_left_q  <= left_tmp_q;
                    count_right_q <= 3'(N_MOL) - left_tmp_q;
                    scan_done_q   <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Clear wins over both the crossing increments and the known flag set by this cycle's evaluation.
            if (bus.clear) begin
                known_q    <= '0;
                total_lr_q <= '0;
                total_rl_q <= '0;
            end else begin
                if (cross_lr && total_lr_q != 8'hff) total_lr_q <= total_lr_q + 8'd1;
                if (cross_rl && total_rl_q != 8'hff) total_rl_q <= total_rl_q + 8'd1;
            end
        end
    end
    assign bus.count_left  = count_left_q;
    assign bus.count_right = count_right_q;
    assign bus.total_lr    = total_lr_q;
    assign bus.total_rl    = total_rl_q;
    assign bus.scan_done   = scan_done_q;
endmodule

// File: tb/tb_molecule_cross_counter.sv
// tb_molecule_cross_counter: directed scenarios for molecule_cross_counter with hand-computed expectations.
module tb_molecule_cross_counter;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    molecule_cross_counter_if bus();
    molecule_cross_counter #(.MOL_SIZE(16), .N_MOL(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic set_pos(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
        bus.pos_x_0 = a; bus.pos_x_1 = b; bus.pos_x_2 = c; bus.pos_x_3 = d;
    endtask
    task automatic run_frame(output int lat);
        @(negedge clk) bus.frame = 1'b1;
        @(negedge clk) bus.frame = 1'b0;
        lat = 0;
        while (!bus.scan_done && lat < 20) begin @(negedge clk); lat++; end
        if (!bus.scan_done) begin checks++; errors++; $display("FAIL frame_timeout scan_done never rose within 20 cycles"); end
    endtask
    task automatic count_pulses(input int n, output int p);
        p = 0;
        repeat (n) begin @(negedge clk); if (bus.scan_done) p++; end
    endtask
    task automatic test_reset;
        reset = 1'b1; bus.frame = 0; bus.freeze = 0; bus.clear = 0; bus.membrane_x = 10'd320;
        set_pos(0, 0, 0, 0);
        #12;
        checks++; if (bus.count_left !== 3'd0) begin errors++; $display("FAIL reset_left got %0d exp 0", bus.count_left); end
        checks++; if (bus.count_right !== 3'd0) begin errors++; $display("FAIL reset_right got %0d exp 0", bus.count_right); end
        checks++; if (bus.total_lr !== 8'd0) begin errors++; $display("FAIL reset_lr got %0d exp 0", bus.total_lr); end
        checks++; if (bus.total_rl !== 8'd0) begin errors++; $display("FAIL reset_rl got %0d exp 0", bus.total_rl); end
        checks++; if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.scan_done); end
        @(negedge clk) reset = 1'b0;
    endtask
    task automatic test_basic;
        int lat;
        set_pos(100, 200, 400, 500);
        run_frame(lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
        checks++; if (bus.count_left !== 3'd2) begin errors++; $display("FAIL basic_left got %0d exp 2", bus.count_left); end
        checks++; if (bus.count_right !== 3'd2) begin errors++; $display("FAIL basic_right got %0d exp 2", bus.count_right); end
        checks++; if (bus.total_lr !== 8'd0 || bus.total_rl !== 8'd0) begin errors++; $display("FAIL basic_totals got %0d/%0d exp 0/0", bus.total_lr, bus.total_rl); end
        @(negedge clk);
        checks++; if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %0b exp 0", bus.scan_done); end
    endtask
    task automatic test_crossing;
        int lat;
        bus.pos_x_0 = 400; run_frame(lat);
        checks++; if (bus.total_lr !== 8'd1) begin errors++; $display("FAIL cross_lr got %0d exp 1", bus.total_lr); end
        checks++; if (bus.count_left !== 3'd1 || bus.count_right !== 3'd3) begin errors++; $display("FAIL cross_lr_counts got %0d/%0d exp 1/3", bus.count_left, bus.count_right); end
        bus.pos_x_0 = 100; run_frame(lat);
        checks++; if (bus.total_rl !== 8'd1) begin errors++; $display("FAIL cross_rl got %0d exp 1", bus.total_rl); end
        checks++; if (bus.count_left !== 3'd2) begin errors++; $display("FAIL cross_rl_left got %0d exp 2", bus.count_left); end
    endtask
    task automatic test_boundary;
        int lat;
        bus.pos_x_0 = 312; run_frame(lat);
        checks++; if (bus.count_left !== 3'd1 || bus.total_lr !== 8'd2) begin errors++; $display("FAIL edge_equal got left %0d lr %0d exp 1 2", bus.count_left, bus.total_lr); end
        bus.pos_x_0 = 311; run_frame(lat);
        checks++; if (bus.count_left !== 3'd2 || bus.total_rl !== 8'd2) begin errors++; $display("FAIL edge_below got left %0d rl %0d exp 2 2", bus.count_left, bus.total_rl); end
        bus.pos_x_0 = 1020; run_frame(lat);
        checks++; if (bus.count_left !== 3'd1 || bus.total_lr !== 8'd3) begin errors++; $display("FAIL edge_nowrap got left %0d lr %0d exp 1 3", bus.count_left, bus.total_lr); end
    endtask
    task automatic test_ignore;
        int p, q, lat;
        p = 0;
        @(negedge clk) bus.frame = 1'b1;
        repeat (6) begin @(negedge clk); bus.pos_x_0 = 100; if (bus.scan_done) p++; end
        bus.frame = 1'b0;
        count_pulses(10, q);
        checks++; if (p + q != 1) begin errors++; $display("FAIL ignore_scan_pulses got %0d exp 1", p + q); end
        checks++; if (bus.count_left !== 3'd1 || bus.total_rl !== 8'd2) begin errors++; $display("FAIL ignore_snapshot got left %0d rl %0d exp 1 2", bus.count_left, bus.total_rl); end
        bus.freeze = 1'b1;
        @(negedge clk) bus.frame = 1'b1;
        @(negedge clk) bus.frame = 1'b0;
        count_pulses(10, p);
        checks++; if (p != 0) begin errors++; $display("FAIL freeze_pulses got %0d exp 0", p); end
        checks++; if (bus.count_left !== 3'd1 || bus.total_rl !== 8'd2) begin errors++; $display("FAIL freeze_counts got left %0d rl %0d exp 1 2", bus.count_left, bus.total_rl); end
        bus.freeze = 1'b0;
        @(negedge clk) bus.frame = 1'b1;
        @(negedge clk) begin bus.frame = 1'b0; bus.freeze = 1'b1; end
        lat = 0;
        while (!bus.scan_done && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 5) begin errors++; $display("FAIL freeze_midscan_latency got %0d exp 5", lat); end
        checks++; if (bus.count_left !== 3'd2 || bus.total_rl !== 8'd3) begin errors++; $display("FAIL freeze_midscan got left %0d rl %0d exp 2 3", bus.count_left, bus.total_rl); end
        bus.freeze = 1'b0;
    endtask
    task automatic test_clear;
        int lat;
        bus.pos_x_0 = 400;
        @(negedge clk) bus.frame = 1'b1;
        @(negedge clk) begin bus.frame = 1'b0; bus.clear = 1'b1; end
        @(negedge clk) bus.clear = 1'b0;
        lat = 0;
        while (!bus.scan_done && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (bus.total_lr !== 8'd0 || bus.total_rl !== 8'd0) begin errors++; $display("FAIL clear_priority got %0d/%0d exp 0/0", bus.total_lr, bus.total_rl); end
        checks++; if (bus.count_left !== 3'd1) begin errors++; $display("FAIL clear_scan_left got %0d exp 1", bus.count_left); end
        bus.pos_x_0 = 100; run_frame(lat);
        checks++; if (bus.total_rl !== 8'd0 || bus.count_left !== 3'd2) begin errors++; $display("FAIL clear_known got rl %0d left %0d exp 0 2", bus.total_rl, bus.count_left); end
        @(negedge clk) bus.clear = 1'b1;
        @(negedge clk) bus.clear = 1'b0;
        checks++; if (bus.count_left !== 3'd2 || bus.count_right !== 3'd2) begin errors++; $display("FAIL clear_keeps_counts got %0d/%0d exp 2/2", bus.count_left, bus.count_right); end
    endtask
    task automatic test_saturation;
        int lat;
        run_frame(lat);
        repeat (150) begin bus.pos_x_0 = 400; run_frame(lat); bus.pos_x_0 = 100; run_frame(lat); end
        checks++; if (bus.total_lr !== 8'd150 || bus.total_rl !== 8'd150) begin errors++; $display("FAIL sat_mid got %0d/%0d exp 150/150", bus.total_lr, bus.total_rl); end
        repeat (106) begin bus.pos_x_0 = 400; run_frame(lat); bus.pos_x_0 = 100; run_frame(lat); end
        checks++; if (bus.total_lr !== 8'd255) begin errors++; $display("FAIL sat_lr got %0d exp 255", bus.total_lr); end
        checks++; if (bus.total_rl !== 8'd255) begin errors++; $display("FAIL sat_rl got %0d exp 255", bus.total_rl); end
    endtask
    task automatic test_reset_mid_scan;
        int p, lat;
        bus.pos_x_0 = 400;
        @(negedge clk) bus.frame = 1'b1;
        @(negedge clk) bus.frame = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.count_left !== 3'd0 || bus.count_right !== 3'd0) begin errors++; $display("FAIL rst_mid_counts got %0d/%0d exp 0/0", bus.count_left, bus.count_right); end
        checks++; if (bus.total_lr !== 8'd0 || bus.total_rl !== 8'd0) begin errors++; $display("FAIL rst_mid_totals got %0d/%0d exp 0/0", bus.total_lr, bus.total_rl); end
        @(negedge clk) reset = 1'b0;
        count_pulses(10, p);
        checks++; if (p != 0 || bus.count_left !== 3'd0) begin errors++; $display("FAIL rst_mid_abandon got pulses %0d left %0d exp 0 0", p, bus.count_left); end
        set_pos(100, 200, 400, 500); run_frame(lat);
        checks++; if (lat != 5 || bus.count_left !== 3'd2 || bus.total_lr !== 8'd0) begin errors++; $display("FAIL rst_after got lat %0d left %0d lr %0d exp 5 2 0", lat, bus.count_left, bus.total_lr); end
        bus.pos_x_0 = 400; run_frame(lat);
        checks++; if (bus.total_lr !== 8'd1) begin errors++; $display("FAIL rst_after_cross got %0d exp 1", bus.total_lr); end
    endtask
    initial begin
        test_reset;
        test_basic;
        test_crossing;
        test_boundary;
        test_ignore;
        test_clear;
        test_saturation;
        test_reset_mid_scan;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/molecule_cross_counter.md
MOLECULE_CROSS_COUNTER -- requirements
Module: molecule_cross_counter

Interface
REQ-001 Parameter: MOL_SIZE, default 16; molecule sprite edge length in pixels.
REQ-002 Parameter: N_MOL, default 4, fixed; number of molecules scanned per frame.
REQ-003 Port clk, input, 1; the single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1; asynchronous, active-high reset.
REQ-005 Port frame, input, 1; one-cycle start-of-frame pulse.
REQ-006 Port freeze, input, 1; when high, frame pulses are ignored.
REQ-007 Port clear, input, 1; synchronous clear of totals and side history.
REQ-008 Port membrane_x, input, 10; membrane column in pixels.
REQ-009 Ports pos_x_0..pos_x_3, input, 10 each; molecule top-left x positions from the molecule blocks.
REQ-010 Port count_left, output, 3; molecules on the left side at the last completed scan.
REQ-011 Port count_right, output, 3; molecules on the right side at the last completed scan.
REQ-012 Port total_lr, output, 8; saturating count of left-to-right crossings.
REQ-013 Port total_rl, output, 8; saturating count of right-to-left crossings.
REQ-014 Port scan_done, output, 1; one-cycle pulse when the count outputs update.

Function
REQ-015 Center: center_i = {1'b0,pos_x_i} + MOL_SIZE/2, evaluated at 11 bits, with no wrap.
REQ-016 Side: right if center_i >= {1'b0,membrane_x}, otherwise left.
REQ-017 FSM states: IDLE, SCAN, DONE.
REQ-018 IDLE: at an edge with frame=1 and freeze=0, all four pos_x values are snapshotted, idx is set to 0, the temporary left count is set to 0, and the state moves to SCAN.
REQ-019 SCAN: each cycle evaluates the snapshot molecule idx, adds 1 to the temporary left count if that molecule is left, and increments idx; after idx=3 the state moves to DONE.
REQ-020 Per molecule i: registers known_i (1 bit) and side_i (1 bit); evaluating i sets side_i to the new side and known_i to 1.
REQ-021 Crossing rule: known_i=1 and side_i changed from left to right increments total_lr; a change from right to left increments total_rl.
REQ-022 A molecule with known_i=0 never counts a crossing; the first frame after reset or clear only establishes sides.
REQ-023 Totals saturate at 255 and never wrap.
REQ-024 DONE lasts one cycle: count_left becomes the temporary count, count_right becomes 4 minus count_left, and scan_done=1; the state then returns to IDLE.
REQ-025 Latency: count_left, count_right and scan_done become valid 5 clock edges after the edge that sampled frame.
REQ-026 A frame pulse while the FSM is in SCAN or DONE is ignored; it is neither queued nor restarts the scan.
REQ-027 freeze=1 does not abort a scan already in progress.
REQ-028 clear=1 zeroes total_lr, total_rl and every known_i on that edge, and takes priority over any increment in the same cycle.
REQ-029 clear does not change the FSM state, count_left, or count_right.
REQ-030 Inputs are used only through the snapshot, so pos_x changes during a scan have no effect on it.

Reset
REQ-031 Reset asserted forces the state to IDLE, idx to 0, all known_i and side_i to 0, count_left, count_right, total_lr and total_rl to 0, and scan_done to 0, immediately and regardless of clk.
REQ-032 Reset asserted during a scan abandons that scan; no partial counts are published after release.
REQ-033 After reset deasserts, the first frame is sampled no earlier than the first rising clock edge.

Verification
REQ-034 Scenario: membrane_x=320, positions {100,200,400,500}, one frame -> scan_done 5 edges later; count_left=2, count_right=2, both totals 0.
REQ-035 Scenario: next frame with pos_x_0=400 -> total_lr=1, count_left=1; next frame with pos_x_0=100 -> total_rl=1.
REQ-036 Scenario: pos_x_0=312 (center 320) with membrane_x=320 -> right; pos_x_0=311 -> left; pos_x_0=1020 -> right (center 1028, no wrap).
REQ-037 Scenario: 300 alternating crossings of molecule 0 -> total_lr=150, total_rl=150; drive 106 more left-to-right crossings -> total_lr holds at 255.
REQ-038 Scenario: frame pulses during SCAN, and a frame with freeze=1 -> no extra scan_done pulse and no count change.
REQ-039 Scenario: clear asserted in the same cycle as a crossing evaluation -> totals=0; reset mid-SCAN -> all outputs 0 immediately and no scan_done pulse.
